// File: rtl/proc_pkg.sv
// Shared definitions for the proc issue arbiter: opcodes, instruction fields,
// FSM encoding and the nominal Done latencies of the proc datapath.
package proc_pkg;

  localparam logic [1:0] OP_MV  = 2'b00;
  localparam logic [1:0] OP_MVI = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  localparam int OP_HI = 7;
  localparam int OP_LO = 6;
  localparam int RX_HI = 5;
  localparam int RX_LO = 3;
  localparam int RY_HI = 2;
  localparam int RY_LO = 0;

  // Cycles from Run to Done on a healthy proc.
  localparam int LAT_MV  = 1;
  localparam int LAT_ALU = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  function automatic int done_lat(input logic [1:0] op);
    return op[1] ? LAT_ALU : LAT_MV;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last
// time is granted; last_grant advances only when en is high.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       last_grant
);

  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | last_grant);
    gnt[1] = req[1] & (~req[0] | ~last_grant);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (en && (req != 2'b00)) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/proc_issue_arb.sv
// Issues instructions from two requesters to a single proc datapath, one at a
// time, and returns the Done-time Bus value (or a watchdog error) to the owner.
// Handshake: reqN_instr is taken in the cycle reqN_valid && reqN_ready; ready
// is combinational, only in IDLE, and at most one requester is ready at once.
module proc_issue_arb
  import proc_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_instr,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_instr,
  output logic          req1_ready,
  output logic          rsp_valid,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          proc_Run,
  output logic [DW-1:0] proc_DIN,
  input  logic          proc_Done,
  input  logic [DW-1:0] proc_Bus,
  output logic          busy,
  output logic          spurious_done,
  output logic [1:0]    state_dbg
);

  localparam logic [3:0] TMO = 4'(TIMEOUT);

  state_e     state;
  logic [3:0] cnt;
  logic       id_q;
  logic [1:0] gnt;
  logic       last_grant;
  logic       in_idle;

  assign in_idle    = (state == S_IDLE);
  assign req0_ready = in_idle & gnt[0];
  assign req1_ready = in_idle & gnt[1];
  assign busy       = ~in_idle;
  assign state_dbg  = state;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       ({req1_valid, req0_valid}),
    .en        (in_idle),
    .gnt       (gnt),
    .last_grant(last_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      id_q          <= 1'b0;
      proc_Run      <= 1'b0;
      proc_DIN      <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
      spurious_done <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      proc_Run  <= 1'b0;
      // Done is only expected while waiting; anything else is latched for debug.
      if (proc_Done && (state != S_WAIT)) spurious_done <= 1'b1;
      case (state)
        S_IDLE: begin
          if (gnt != 2'b00) begin
            proc_Run <= 1'b1;
            proc_DIN <= gnt[1] ? req1_instr : req0_instr;
            id_q     <= gnt[1];
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= 4'd1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Done takes priority over the watchdog when both land together.
          if (proc_Done) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_data  <= proc_Bus;
            rsp_err   <= 1'b0;
            cnt       <= 4'd0;
            state     <= S_IDLE;
          end else if (cnt == TMO) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            cnt       <= 4'd0;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_issue_arb.sv
// Bench for proc_issue_arb: a transaction-level model predicts grants, Run,
// busy and response timing from each accepted instruction and its Done delay.
module tb_proc_issue_arb;
  import proc_pkg::*;

  localparam int TIMEOUT = 8;
  localparam int DW      = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_instr, req1_instr;
  logic          req0_ready, req1_ready;
  logic          rsp_valid, rsp_id, rsp_err;
  logic [DW-1:0] rsp_data;
  logic          proc_Run, proc_Done, busy, spurious_done;
  logic [DW-1:0] proc_DIN, proc_Bus;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  proc_issue_arb #(.TIMEOUT(TIMEOUT), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_instr   (req0_instr),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_instr   (req1_instr),
    .req1_ready   (req1_ready),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .proc_Run     (proc_Run),
    .proc_DIN     (proc_DIN),
    .proc_Done    (proc_Done),
    .proc_Bus     (proc_Bus),
    .busy         (busy),
    .spurious_done(spurious_done),
    .state_dbg    (state_dbg)
  );

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic chk_en = 1'b0;
  logic release_now = 1'b0;

  // Model: one transaction in flight, described by the cycles of its events.
  int         m_last, m_rsp_cyc, m_run_cyc, m_done_cyc;
  logic       m_spur;
  logic [7:0] m_din, m_din_pend, m_done_bus;
  logic [9:0] exp_q[$];
  logic       e_r0, e_r1, e_run, e_rv, e_busy, e_spur;
  logic [7:0] e_din;
  logic [9:0] e_rsp;

  function automatic void model_reset();
    m_last     = 1;
    m_rsp_cyc  = -1;
    m_run_cyc  = -1;
    m_done_cyc = -1;
    m_spur     = 1'b0;
    m_din      = 8'h00;
    exp_q.delete();
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus. dly = cycles from Run to Done for an
  // instruction granted this cycle (> TIMEOUT means the proc never answers).
  task automatic cycle(input logic v0, input logic [7:0] i0, input logic v1,
                       input logic [7:0] i1, input int dly, input logic [7:0] bus,
                       input logic spur_req);
    logic in_wait, idle, done;
    int   g;
    @(posedge clk);
    #1;
    if (release_now) begin
      rst_n       = 1'b1;
      release_now = 1'b0;
      model_reset();
      chk_en      = 1'b1;
    end
    cyc++;
    in_wait = (m_run_cyc >= 0) && (cyc > m_run_cyc) && (cyc < m_rsp_cyc);
    idle    = (cyc >= m_rsp_cyc);
    done    = (cyc == m_done_cyc) || (spur_req && !in_wait);
    if (cyc == m_run_cyc) m_din = m_din_pend;
    e_run  = (cyc == m_run_cyc);
    e_din  = m_din;
    e_rv   = (cyc == m_rsp_cyc);
    e_busy = !idle;
    e_spur = m_spur;
    proc_Bus = (cyc == m_done_cyc) ? m_done_bus : 8'($urandom);
    if (done && !in_wait) m_spur = 1'b1;
    e_r0 = 1'b0;
    e_r1 = 1'b0;
    if (idle && (v0 || v1)) begin
      g = (v0 && v1) ? ((m_last == 0) ? 1 : 0) : (v1 ? 1 : 0);
      m_last     = g;
      e_r0       = (g == 0);
      e_r1       = (g == 1);
      m_run_cyc  = cyc + 1;
      m_din_pend = g[0] ? i1 : i0;
      if (dly <= TIMEOUT) begin
        m_done_cyc = cyc + 1 + dly;
        m_done_bus = bus;
        m_rsp_cyc  = cyc + 2 + dly;
        exp_q.push_back({1'b0, g[0], bus});
      end else begin
        m_done_cyc = -1;
        m_rsp_cyc  = cyc + 2 + TIMEOUT;
        exp_q.push_back({1'b1, g[0], 8'h00});
      end
    end
    req0_valid = v0;
    req0_instr = i0;
    req1_valid = v1;
    req1_instr = i1;
    proc_Done  = done;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    chk_en      = 1'b0;
    rst_n       = 1'b0;
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    proc_Done   = 1'b0;
    release_now = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("ready_onehot", req0_ready & req1_ready, 0);
      chk("proc_Run", proc_Run, e_run);
      chk("proc_DIN", proc_DIN, e_din);
      chk("busy", busy, e_busy);
      chk("state_idle", state_dbg == 2'd0, !e_busy);
      chk("spurious_done", spurious_done, e_spur);
      chk("rsp_valid", rsp_valid, e_rv);
      if (e_rv && exp_q.size() > 0) begin
        e_rsp = exp_q.pop_front();
        if (rsp_valid) chk("rsp_fields", {rsp_err, rsp_id, rsp_data}, e_rsp);
      end
    end
  end

  int exp_ord[6] = '{0, 1, 0, 1, 0, 1};
  int order[$];
  int t_timeout;

  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_instr = 8'h00; req1_instr = 8'h00;
    proc_Done  = 1'b0;  proc_Bus   = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_run", proc_Run, 0);
    chk("rst_din", proc_DIN, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_spurious", spurious_done, 0);
    chk("rst_state", state_dbg, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    release_now = 1'b1;

    // mvi R1,#1 from requester 0
    cycle(1'b1, 8'h49, 1'b0, 8'h00, LAT_MV, 8'h01, 1'b0);
    @(negedge clk); chk("t1_ready0", req0_ready, 1);
    idle_cycle();
    @(negedge clk); chk("t1_run", proc_Run, 1); chk("t1_din", proc_DIN, 8'h49);
    idle_cycle();
    idle_cycle();
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 1); chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_data", rsp_data, 8'h01); chk("t1_rsp_err", rsp_err, 0);

    // add R1,R2 from requester 1
    cycle(1'b0, 8'h00, 1'b1, 8'h8A, LAT_ALU, 8'h03, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      idle_cycle();
      @(negedge clk); chk("t2_busy", busy, 1);
    end
    idle_cycle();
    @(negedge clk);
    chk("t2_rsp_valid", rsp_valid, 1); chk("t2_rsp_id", rsp_id, 1);
    chk("t2_rsp_data", rsp_data, 8'h03);

    // both requesters valid every cycle from reset
    do_reset();
    for (int k = 0; k < 80 && order.size() < 6; k++) begin
      cycle(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1, 8'($urandom), 1'b0);
      @(negedge clk);
      if (req0_ready) order.push_back(0);
      else if (req1_ready) order.push_back(1);
    end
    for (int i = 0; i < 6; i++)
      chk("t3_grant_order", (i < order.size()) ? order[i] : 9, exp_ord[i]);
    repeat (6) idle_cycle();

    // proc never answers: watchdog response, then a normal request
    cycle(1'b1, 8'h55, 1'b0, 8'h00, 99, 8'h00, 1'b0);
    t_timeout = cyc;
    repeat (9) begin
      idle_cycle();
      @(negedge clk); chk("t4_no_early_rsp", rsp_valid, 0);
    end
    cycle(1'b0, 8'h00, 1'b1, 8'h12, 2, 8'h34, 1'b0);
    @(negedge clk);
    chk("t4_rsp_cycle", cyc - t_timeout, 10);
    chk("t4_rsp_valid", rsp_valid, 1); chk("t4_rsp_err", rsp_err, 1);
    chk("t4_rsp_data", rsp_data, 0); chk("t4_next_ready1", req1_ready, 1);
    repeat (6) idle_cycle();

    // Done while idle
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1, 8'h00, 1'b1);
    idle_cycle();
    @(negedge clk); chk("t5_spurious", spurious_done, 1); chk("t5_no_rsp", rsp_valid, 0);
    cycle(1'b1, 8'h40, 1'b0, 8'h00, LAT_MV, 8'h77, 1'b0);
    repeat (4) idle_cycle();

    // reset in WAIT of an add, Done arrives after release
    cycle(1'b0, 8'h00, 1'b1, 8'h8B, LAT_ALU, 8'h09, 1'b0);
    idle_cycle();
    idle_cycle();
    do_reset();
    #1;
    chk("t6_run", proc_Run, 0); chk("t6_din", proc_DIN, 0);
    chk("t6_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, 0);
    chk("t6_busy", busy, 0); chk("t6_spurious", spurious_done, 0);
    chk("t6_ready", {req1_ready, req0_ready}, 0);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1, 8'h00, 1'b1);
    idle_cycle();
    @(negedge clk); chk("t6_late_spurious", spurious_done, 1);
    repeat (4) idle_cycle();

    // randomized traffic, including hangs and stray Done pulses
    repeat (600) begin
      cycle($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
            8'($urandom), $urandom_range(1, TIMEOUT + 2), 8'($urandom),
            $urandom_range(0, 15) == 0);
    end
    repeat (14) idle_cycle();
    @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/proc_issue_arb.md
Name: proc_issue_arb

Overview:
- Shares one proc datapath between two instruction requesters.
- Accepts 8-bit instructions over valid/ready and arbitrates round-robin between the requesters.
- Drives the proc Run/DIN pulse, waits for Done, and returns the Bus value tagged with the requester id.
- A watchdog turns a missing Done into an error response, so a hung datapath never deadlocks the requesters.

Parameters:
- TIMEOUT, 8: number of WAIT cycles without proc_Done before an error response is forced (legal range 4..15).
- DW, 8: instruction and data width, matching the proc DIN/Bus width.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an instruction.
- req0_instr  in  DW  requester 0 instruction {op[7:6], X[5:3], Y[2:0]}.
- req0_ready  out  1  requester 0 instruction accepted this cycle.
- req1_valid, req1_instr, req1_ready: same as requester 0, for requester 1.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  1  requester the response belongs to.
- rsp_data  out  DW  proc Bus value captured with Done; 0 on error.
- rsp_err  out  1  response is a timeout.
- proc_Run  out  1  Run to proc.
- proc_DIN  out  DW  DIN to proc.
- proc_Done  in  1  Done from proc.
- proc_Bus  in  DW  Bus from proc.
- busy  out  1  high in ISSUE or WAIT.
- spurious_done  out  1  sticky flag: proc_Done was seen outside WAIT.

Behaviour:
- Reset (async, Reset=0):
  - state=IDLE, last_grant=1, wait counter=0.
  - All outputs 0; proc_DIN=0.
  - Reset mid-operation aborts the in-flight instruction with no response. proc_Run drops immediately.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any reqN_valid, grant one and assert its reqN_ready combinationally in the same cycle. Only IDLE may assert ready.
  - Register the granted instr and id, then go to ISSUE.
  - Grant rule: if only one requester is valid, grant it. If both are valid, grant the one != last_grant. last_grant updates on grant.
- ISSUE:
  - proc_Run=1 and proc_DIN=instr, both registered, for exactly one cycle. Go to WAIT with counter=1.
- WAIT:
  - proc_Run=0; proc_DIN holds its value (don't care to proc).
  - On proc_Done=1: register rsp_valid=1, rsp_id, rsp_data=proc_Bus, rsp_err=0; go to IDLE.
  - Else if counter==TIMEOUT: register rsp_valid=1, rsp_data=0, rsp_err=1; go to IDLE.
  - Else counter+1.
  - Done and timeout in the same cycle: Done wins.
- rsp_valid is high for exactly the first IDLE cycle after WAIT. A new grant may occur in that same cycle.
- Latency, with acceptance in cycle N:
  - proc_Run in N+1.
  - mv (op 00) / mvi (op 01): proc_Done in N+2, rsp_valid in N+3.
  - add (op 10) / sub (op 11): proc_Done in N+4, rsp_valid in N+5.
- Throughput: at most one instruction outstanding. The proc is never given Run while busy.
- No decode or legality check: the instruction is passed through unmodified. Op field is used only for optional assertions.
- spurious_done sets when proc_Done=1 in IDLE or ISSUE. It clears only on Reset.
- A reqN_valid deasserted before grant is legal. instr is sampled only in the grant cycle.

Decomposition:
- Package proc_pkg holds:
  - Opcodes OP_MV=2'b00, OP_MVI=2'b01, OP_ADD=2'b10, OP_SUB=2'b11.
  - Field positions: OP [7:6], RX [5:3], RY [2:0].
  - FSM state encoding.
  - Expected Done latencies: LAT_MV=1, LAT_ALU=3.
- One sub-module, rr_arb2: 2-way round-robin grant with last_grant register and update enable.
- The top holds the FSM, watchdog counter, and response registers.

Test Plan:
- Reset, then req0 instr 0x49 (mvi R1,#1). Required: proc_Run in N+1 with DIN=0x49; rsp_valid in N+3 with id=0, data=1, err=0.
- req1 instr 0x8A (add R1,R2) with model Done 3 cycles after Run and Bus=3. Required: rsp in N+5 with id=1, data=3; busy high for N+1..N+4.
- Both requesters valid every cycle for 6 grants from reset. Required: grant order 0,1,0,1,0,1; ready never asserted outside IDLE; never two readys at once.
- Model never asserts Done, TIMEOUT=8. Required: rsp_valid with err=1, data=0 exactly 8 WAIT cycles after ISSUE; next request then accepted normally.
- Done pulsed while IDLE. Required: spurious_done=1 and stays high; no rsp_valid; normal operation continues.
- Reset asserted in the WAIT of an add, with Done arriving after release. Required: all outputs 0 immediately; no rsp_valid after release; spurious_done set by the late Done.
